// File: rtl/event_timer_array.sv
// Bank of independent elapsed-time counters with start/capture edge detection,
// a saturating count with a sticky overflow flag, and a one-shot alarm per channel.
module event_timer_array #(
    parameter int TIMER_BITWIDTH = 32,
    parameter int NB_INSTANCES   = 10
) (
    input  logic                                   clk,
    input  logic                                   areset_n,
    input  logic                                   sreset,
    input  logic [NB_INSTANCES-1:0]                start,
    input  logic [NB_INSTANCES-1:0]                capture,
    input  logic [NB_INSTANCES-1:0]                rst_capture,
    input  logic [NB_INSTANCES-1:0]                alarm_load,
    input  logic [TIMER_BITWIDTH-1:0]              alarm_time,
    output logic [NB_INSTANCES*TIMER_BITWIDTH-1:0] cap_value,
    output logic [NB_INSTANCES-1:0]                cap_valid,
    output logic [NB_INSTANCES-1:0]                running,
    output logic [NB_INSTANCES-1:0]                overflow,
    output logic [NB_INSTANCES-1:0]                alarm
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [TIMER_BITWIDTH-1:0] CNT_ZERO = '0;
    localparam logic [TIMER_BITWIDTH-1:0] CNT_MAX  = '1;
    localparam logic [TIMER_BITWIDTH-1:0] CNT_ONE  = TIMER_BITWIDTH'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NB_INSTANCES; gi++) begin : g_ch
            logic                      state_q, state_d;
            logic [TIMER_BITWIDTH-1:0] count_q, count_d;
            logic [TIMER_BITWIDTH-1:0] cap_q, cap_d;
            logic [TIMER_BITWIDTH-1:0] thr_q, thr_d;
            logic                      cap_valid_q, cap_valid_d;
            logic                      ovf_q, ovf_d;
            logic                      alarm_q, alarm_d;
            logic                      armed_q, armed_d;
            logic                      start_q, capture_q;
            logic                      start_edge, capture_edge;
            logic                      at_max;
            logic [TIMER_BITWIDTH-1:0] elapsed;

            assign start_edge   = start[gi] & ~start_q;
            assign capture_edge = capture[gi] & ~capture_q;
            assign at_max       = (count_q == CNT_MAX);
            // Elapsed clocks as of the current sampling edge (count_q lags by one).
            assign elapsed      = at_max ? CNT_MAX : count_q + CNT_ONE;

            always_comb begin
                state_d     = state_q;
                count_d     = count_q;
                cap_d       = cap_q;
                thr_d       = thr_q;
                cap_valid_d = 1'b0;
                ovf_d       = ovf_q;
                alarm_d     = alarm_q;
                armed_d     = armed_q;

                if (rst_capture[gi]) begin
                    state_d = ST_IDLE;
                    count_d = CNT_ZERO;
                    cap_d   = CNT_ZERO;
                    ovf_d   = 1'b0;
                    alarm_d = 1'b0;
                    armed_d = 1'b0;
                end else begin
                    if (alarm_load[gi]) begin
                        thr_d   = alarm_time;
                        armed_d = 1'b1;
                        alarm_d = 1'b0;
                    end
                    if (state_q == ST_RUN) begin
                        // Capture sees the old run even when a restart lands on the same edge.
                        if (capture_edge) begin
                            cap_d       = elapsed;
                            cap_valid_d = 1'b1;
                        end
                        if (start_edge) begin
                            count_d = CNT_ZERO;
                            ovf_d   = 1'b0;
                            if (armed_d && thr_d == CNT_ZERO) begin
                                alarm_d = 1'b1;
                                armed_d = 1'b0;
                            end
                        end else begin
                            count_d = elapsed;
                            if (elapsed == CNT_MAX) begin
                                ovf_d = 1'b1;
                            end
                            if (armed_d && !at_max && elapsed == thr_d) begin
                                alarm_d = 1'b1;
                                armed_d = 1'b0;
                            end
                        end
                    end else if (start_edge) begin
                        state_d = ST_RUN;
                        count_d = CNT_ZERO;
                        ovf_d   = 1'b0;
                        if (armed_d && thr_d == CNT_ZERO) begin
                            alarm_d = 1'b1;
                            armed_d = 1'b0;
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge areset_n) begin
                if (!areset_n) begin
                    state_q     <= ST_IDLE;
                    count_q     <= CNT_ZERO;
                    cap_q       <= CNT_ZERO;
                    thr_q       <= CNT_ZERO;
                    cap_valid_q <= 1'b0;
                    ovf_q       <= 1'b0;
                    alarm_q     <= 1'b0;
                    armed_q     <= 1'b0;
                    start_q     <= 1'b0;
                    capture_q   <= 1'b0;
                end else if (sreset) begin
                    state_q     <= ST_IDLE;
                    count_q     <= CNT_ZERO;
                    cap_q       <= CNT_ZERO;
                    thr_q       <= CNT_ZERO;
                    cap_valid_q <= 1'b0;
                    ovf_q       <= 1'b0;
                    alarm_q     <= 1'b0;
                    armed_q     <= 1'b0;
                    start_q     <= 1'b0;
                    capture_q   <= 1'b0;
                end else begin
                    state_q     <= state_d;
                    count_q     <= count_d;
                    cap_q       <= cap_d;
                    thr_q       <= thr_d;
                    cap_valid_q <= cap_valid_d;
                    ovf_q       <= ovf_d;
                    alarm_q     <= alarm_d;
                    armed_q     <= armed_d;
                    start_q     <= start[gi];
                    capture_q   <= capture[gi];
                end
            end

            assign cap_value[gi*TIMER_BITWIDTH +: TIMER_BITWIDTH] = cap_q;
            assign cap_valid[gi] = cap_valid_q;
            assign running[gi]   = (state_q == ST_RUN);
            assign overflow[gi]  = ovf_q;
            assign alarm[gi]     = alarm_q;
        end
    endgenerate

endmodule
